// File: rtl/fxp_pkg.sv
// Shared constants, types and the clamp function for the Q11.5 + Q11.5 -> Q12.4
// saturating adder. The optional ADDER_ROUND_EN macro (see fxp_saturate) only
// changes how the sum is narrowed; every type and bound defined here is the
// same in both builds.
package fxp_pkg;

   localparam int WIDTH    = 16;                 // width of A, B and sum
   localparam int FRAC_IN  = 5;                  // fractional bits of A and B
   localparam int FRAC_OUT = 4;                  // fractional bits of sum
   localparam int SHIFT    = FRAC_IN - FRAC_OUT; // bits dropped when narrowing

   // Half of one output LSB, expressed in input LSBs (used when rounding).
   localparam int ROUND_HALF = 2 ** (SHIFT - 1);

   typedef logic signed [WIDTH-1:0] fxp_in_t;   // Q11.5 operand
   typedef logic signed [WIDTH-1:0] fxp_out_t;  // Q12.4 result
   typedef logic signed [WIDTH:0]   fxp_sum_t;  // exact Q12.5 sum
   typedef logic signed [WIDTH+1:0] fxp_ext_t;  // headroom for the rounding add

   // Output range equals the input integer range: [-1024.0, +1023.9375].
   localparam fxp_out_t SAT_MAX = fxp_out_t'((2 ** (WIDTH-1) - 1) >>> SHIFT);
   localparam fxp_out_t SAT_MIN = fxp_out_t'((-(2 ** (WIDTH-1))) >>> SHIFT);
   localparam fxp_ext_t EXT_MAX = fxp_ext_t'((2 ** (WIDTH-1) - 1) >>> SHIFT);
   localparam fxp_ext_t EXT_MIN = fxp_ext_t'((-(2 ** (WIDTH-1))) >>> SHIFT);

   // Clamp an already-shifted value into the output range.
   function automatic fxp_out_t saturate(input fxp_ext_t v);
      fxp_out_t r;
      if (v > EXT_MAX) begin
         r = SAT_MAX;
      end else if (v < EXT_MIN) begin
         r = SAT_MIN;
      end else begin
         r = v[WIDTH-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/fxp_saturate.sv
// Combinational narrowing of the exact Q12.5 sum to Q12.4 with clamping.
// Build option: define ADDER_ROUND_EN to round half-up before the shift;
// otherwise the shift truncates toward -inf. Saturation always follows
// the (optionally rounded) shift.
module fxp_saturate
   import fxp_pkg::*;
(
   input  logic [WIDTH:0]   sum_in,
   output logic [WIDTH-1:0] sat_out
);

   fxp_ext_t ext;
   fxp_ext_t shifted;

   // Sign-extend into two bits of headroom, optionally round, shift, clamp.
   always_comb begin
      ext = $signed({sum_in[WIDTH], sum_in});
`ifdef ADDER_ROUND_EN
      ext = ext + fxp_ext_t'(ROUND_HALF);
`else
      ext = ext;
`endif
      shifted = ext >>> SHIFT;
      sat_out = saturate(shifted);
   end

endmodule

// File: rtl/fixed_point_add_sat.sv
// Two-stage pipelined saturating fixed-point adder (Q11.5 + Q11.5 -> Q12.4).
// Stage 1 registers the operands when enable is high and raises v1; stage 2
// loads the narrowed, clamped sum when v1 is set and otherwise holds it, so
// the result is available one edge after the capturing edge and persists
// until the next enabled operation. Reset clears everything asynchronously.
// Build option: ADDER_ROUND_EN selects round-half-up instead of truncation
// (handled inside fxp_saturate); ports and timing are unchanged.
module fixed_point_add_sat
   import fxp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] sum
);

   fxp_in_t  a1_q, a1_d;
   fxp_in_t  b1_q, b1_d;
   logic     v1_q, v1_d;
   fxp_out_t sum_q, sum_d;

   fxp_sum_t   add_full;
   logic [WIDTH-1:0] sat_val;

   // Stage 1 next state: capture operands on enable, otherwise hold them.
   always_comb begin
      a1_d = a1_q;
      b1_d = b1_q;
      v1_d = enable;
      if (enable) begin
         a1_d = A;
         b1_d = B;
      end
   end

   // Exact WIDTH+1-bit sum of the captured operands; cannot overflow.
   always_comb begin
      add_full = $signed({a1_q[WIDTH-1], a1_q}) + $signed({b1_q[WIDTH-1], b1_q});
   end

   fxp_saturate u_sat (
      .sum_in  (add_full),
      .sat_out (sat_val)
   );

   // Stage 2 next state: load the clamped result only for a valid operation.
   always_comb begin
      sum_d = sum_q;
      if (v1_q) begin
         sum_d = sat_val;
      end
   end

   // Pipeline registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a1_q  <= '0;
         b1_q  <= '0;
         v1_q  <= 1'b0;
         sum_q <= '0;
      end else begin
         a1_q  <= a1_d;
         b1_q  <= b1_d;
         v1_q  <= v1_d;
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: tb/tb_fixed_point_add_sat.sv
// Self-checking bench for fixed_point_add_sat. Stimulus pushes expected results
// into a queue; a negedge monitor pops one whenever an operation is due to land
// and otherwise requires sum to hold. Define ADDER_ROUND_EN for both the bench
// and the RTL to exercise the rounding build.
module tb_fixed_point_add_sat;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [15:0] sum;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_hold = 16'h0000;
   bit          pend  = 1'b0;
   bit          fired = 1'b0;

   fixed_point_add_sat dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .A      (A),
      .B      (B),
      .sum    (sum)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Reference: exact integer sum, optional +half LSB, floor divide, clamp.
   function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
      int s;
      int q;
      s = $signed(a) + $signed(b);
`ifdef ADDER_ROUND_EN
      s = s + 1;
`endif
      q = (s - (((s % 2) + 2) % 2)) / 2;
      if (q > 16383)  q = 16383;
      if (q < -16384) q = -16384;
      return q[15:0];
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: sum=%h expected %h", name, $time, got, exp);
      end
   endtask

   // Track which edges carry a valid operation into stage 2.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  = 1'b0;
         fired = 1'b0;
      end else begin
         fired = pend;
         pend  = enable;
      end
   end

   // Monitor: on an update edge pop the next expected value, else expect a hold.
   always @(negedge clk) begin
      if (!rst) begin
         if (fired) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL underflow at %0t: sum=%h with no expected value queued", $time, sum);
            end else begin
               exp_hold = exp_q.pop_front();
               check("update", sum, exp_hold);
            end
         end else begin
            check("hold", sum, exp_hold);
         end
      end
   end

   // Drive one cycle of inputs shortly after the rising edge.
   task automatic drive(input logic en, input logic [15:0] a, input logic [15:0] b);
      @(posedge clk);
      #2;
      enable = en;
      A = a;
      B = b;
      if (en && !rst) exp_q.push_back(ref_sum(a, b));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 16'($urandom));
   endtask

   function automatic logic [15:0] pick_operand();
      logic [15:0] v;
      case ($urandom_range(0, 7))
         0: v = 16'h7FFF;
         1: v = 16'h8000;
         2: v = 16'($urandom_range(0, 3));
         3: v = 16'hFFFF - 16'($urandom_range(0, 3));
         default: v = 16'($urandom);
      endcase
      return v;
   endfunction

   // Watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Main stimulus.
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset", sum, 16'h0000);
      #1;
      rst = 1'b0;

      // Directed cases, each followed by idle cycles with toggling inputs.
      drive(1'b1, 16'h7FFF, 16'h7FFF); idle(2);
      drive(1'b1, 16'h0050, 16'h2030); idle(2);
      drive(1'b1, 16'hFC40, 16'h0080); idle(2);
      drive(1'b1, 16'h8000, 16'hC000); idle(2);
      drive(1'b1, 16'h0001, 16'h0000); idle(2);
      drive(1'b1, 16'hFFFF, 16'h0000); idle(2);

      // Back-to-back operations.
      drive(1'b1, 16'h0050, 16'h2030);
      drive(1'b1, 16'h7FFF, 16'h0001);
      drive(1'b1, 16'hFC40, 16'h0080);
      idle(3);

      // Reset one cycle after enable: in-flight op dropped, sum clears at once.
      drive(1'b1, 16'h7FFF, 16'h7FFF);
      @(posedge clk);
      #2;
      rst = 1'b1;
      enable = 1'b1;
      A = 16'h0050;
      B = 16'h2030;
      #1;
      check("rst_async", sum, 16'h0000);
      exp_q.delete();
      exp_hold = 16'h0000;
      @(posedge clk);
      #1;
      check("rst_held", sum, 16'h0000);
      #1;
      rst = 1'b0;
      enable = 1'b0;
      idle(4);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 1)), pick_operand(), pick_operand());
      end
      idle(4);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected results never observed", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
